pio_in_debounce: RTL and testbench
==================================

PIO_IN_DEBOUNCE -- requirements
Module: pio_in_debounce

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, input bit count (1..32); SYNC_STAGES, 2, synchroniser depth (2..3); DEB_CYCLES, 4, debounce qualification cycles (>=1).
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-003 Ports SHALL be: address  in  3  register select; chipselect  in  1  slave select; write_n  in  1  active-low write strobe; writedata  in  32  write data.
REQ-004 Ports SHALL be: in_port  in  WIDTH  asynchronous inputs; readdata  out  32  registered read data; irq  out  1  interrupt request.

Function
REQ-005 Register map SHALL be: 0 DATA (RO, filtered inputs); 1 RISE_EN (RW); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (RW1C); 4 FALL_EN (RW); 5-7 read 0, writes ignored.
REQ-006 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; writedata[WIDTH-1:0] is used; upper bits are ignored.
REQ-007 readdata SHALL be updated on every clk edge from the address mux (1-cycle read latency, chipselect ignored); bits [31:WIDTH] SHALL read 0.
REQ-008 Each in_port bit SHALL pass through a SYNC_STAGES-flop synchroniser before any other use.
REQ-009 Filtered value "stable" SHALL feed DATA; stable_d SHALL be stable delayed by one clk.
REQ-010 rise = stable & ~stable_d; fall = ~stable & stable_d; event = (rise & RISE_EN) | (fall & FALL_EN).
REQ-011 An EDGE_CAPTURE bit SHALL set on the clk edge after its event bit is 1 and hold until cleared.
REQ-012 Writing 1 to an EDGE_CAPTURE bit SHALL clear only that bit; writing 0 SHALL leave it unchanged.
REQ-013 If set and clear hit the same bit on the same edge, set SHALL win.
REQ-014 irq SHALL equal |(EDGE_CAPTURE & IRQ_MASK), combinational from registers, with no extra latency.
REQ-015 Changing RISE_EN/FALL_EN SHALL NOT retroactively set or clear EDGE_CAPTURE bits.

Reset
REQ-016 With reset=1 at a clk edge: synchroniser, stable, stable_d, debounce counters, RISE_EN, IRQ_MASK, EDGE_CAPTURE and readdata SHALL become 0; FALL_EN SHALL become all-ones (falling-edge default).
REQ-017 Reset asserted mid-debounce or mid-capture SHALL discard pending state with no event generated.
REQ-018 irq SHALL be 0 on the cycle after reset is sampled.

Configuration
REQ-019 Macro PIO_IN_DEBOUNCE_EN SHALL control debounce.
REQ-020 Defined: per bit, a counter of width $clog2(DEB_CYCLES+1) increments while sync_out != stable and clears when they match; when the count reaches DEB_CYCLES-1 with a mismatch, stable SHALL take sync_out and the counter SHALL clear.
REQ-021 Defined: a mismatch lasting fewer than DEB_CYCLES consecutive cycles SHALL NOT change stable.
REQ-022 Undefined: stable SHALL take sync_out every cycle; no counters SHALL be instantiated; DEB_CYCLES SHALL be ignored.

Structure
REQ-023 Package pio_in_pkg SHALL hold the register address constants (ADDR_DATA..ADDR_FALL_EN), the FALL_EN reset value rule and the read-zero constant.
REQ-024 Per-bit synchroniser plus debounce SHALL be sub-module pio_in_filter, instantiated WIDTH times with a generate loop; edge logic, registers and the mux SHALL stay in the top level.

Verification (WIDTH=18, SYNC_STAGES=2, DEB_CYCLES=4, macro defined unless noted)
REQ-025 Reset: reads of addr 0/1/2/3/4/5 -> 0x0/0x0/0x0/0x0/0x3FFFF/0x0; irq=0.
REQ-026 in_port=0x3FFFF, then bit5 low held 10 cycles, IRQ_MASK=0x20 -> EDGE_CAPTURE=0x20, irq=1; write 0x20 to addr 3 -> 0x0, irq=0.
REQ-027 EDGE_CAPTURE=0x21; write 0x01 to addr 3 -> reads 0x20; irq stays 1 with IRQ_MASK=0x20.
REQ-028 Write-1-to-clear of bit5 on the same edge as a new bit5 event -> bit5 reads 1.
REQ-029 Bit0 low pulse of 3 cycles -> DATA and EDGE_CAPTURE unchanged; low for 4+ cycles -> DATA bit0=0, capture bit0=1; macro undefined: a 1-cycle pulse is captured.
REQ-030 RISE_EN=0x1, FALL_EN=0x0; bit0 0->1->0 -> EDGE_CAPTURE=0x1 after the rise only; falling edge adds nothing.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced parallel-input block: register
// addresses, the FALL_EN reset-value rule and the read-zero constant.
package pio_in_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd4;

    localparam logic [31:0] READ_ZERO = 32'h0000_0000;

    // FALL_EN comes out of reset with every implemented bit set, so a
    // falling edge on any input is captured by default.
    function automatic logic [31:0] fall_en_reset(input int width);
        logic [31:0] mask;
        if (width >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'h1 << width) - 32'h1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pio_in_filter.sv
// One input bit: SYNC_STAGES-flop synchroniser followed by an optional
// debounce filter. Build with PIO_IN_DEBOUNCE_EN defined to enable the
// DEB_CYCLES qualification counter; without it the synchronised value is
// passed straight through one register and DEB_CYCLES has no effect.
module pio_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    // Metastability synchroniser: shift the asynchronous input in.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Qualify a change only after DEB_CYCLES consecutive mismatching
    // cycles; any cycle that agrees with stable restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_out != stable) begin
            if (cnt == CNT_LAST) begin
                stable <= sync_out;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    // No filtering: follow the synchronised input every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
        end else begin
            stable <= sync_out;
        end
    end
`endif

endmodule

// File: rtl/pio_in_debounce.sv
// Debounced parallel-input port with edge capture and interrupt.
// Per-bit synchroniser/debounce lives in pio_in_filter; the edge
// detector, slave registers, read mux and irq are here.
// Optional feature macro: PIO_IN_DEBOUNCE_EN (debounce counters).
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [31:0] FALL_EN_RST = fall_en_reset(WIDTH);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wdata;
    logic             wr;
    logic [31:0]      rd_mux;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_filter
            pio_in_filter #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEB_CYCLES (DEB_CYCLES)
            ) u_filter (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[gi]),
                .stable(stable[gi])
            );
        end
        if (WIDTH < 32) begin : g_wr_hi
            logic unused_wr_hi;
            assign unused_wr_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    assign rise     = stable & ~stable_d;
    assign fall     = ~stable & stable_d;
    assign edge_evt = (rise & rise_en) | (fall & fall_en);

    // Write-1-to-clear mask for the capture register.
    assign cap_clr = (wr && (address == ADDR_EDGE_CAPTURE)) ? wdata : '0;

    // One-cycle-delayed copy of the filtered value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    // Control registers written through the slave port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en  <= '0;
            irq_mask <= '0;
            fall_en  <= FALL_EN_RST[WIDTH-1:0];
        end else if (wr) begin
            case (address)
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                default: ;
            endcase
        end
    end

    // Edge capture: sticky set from events, cleared by write-1, and a
    // new event on the same edge as its clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
        end
    end

    // Read mux; unimplemented upper bits and addresses read as zero.
    always_comb begin
        rd_mux = READ_ZERO;
        case (address)
            ADDR_DATA:         rd_mux = 32'(stable);
            ADDR_RISE_EN:      rd_mux = 32'(rise_en);
            ADDR_IRQ_MASK:     rd_mux = 32'(irq_mask);
            ADDR_EDGE_CAPTURE: rd_mux = 32'(edge_cap);
            ADDR_FALL_EN:      rd_mux = 32'(fall_en);
            default:           rd_mux = READ_ZERO;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of select.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= READ_ZERO;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce.sv
// Directed, table-driven bench for pio_in_debounce (WIDTH=18,
// SYNC_STAGES=2, DEB_CYCLES=4). Expectations follow PIO_IN_DEBOUNCE_EN.
module tb_pio_in_debounce;

    localparam int WIDTH = 18;
    localparam logic [31:0] ALL1 = 32'h0003_FFFF;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int EVT_PRE = 6;   // posedges after input change before capture edge
`else
    localparam bit DEB_ON = 1'b0;
    localparam int EVT_PRE = 3;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'h0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t rst_tab [8];
    vec_t reg_tab [12];

    pio_in_debounce #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(2),
        .DEB_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        @(negedge clk);
        d = readdata;
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        do_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_table(input vec_t t);
        if (t.wr) do_write(t.addr, t.data);
        else      rd_check(t.addr, t.exp, t.name);
    endtask

    initial begin
        // Reset-state reads: address 0..7.
        for (int i = 0; i < 8; i++) begin
            rst_tab[i] = '{1'b0, 3'(i), 32'h0, 32'h0, $sformatf("rst_addr%0d", i)};
        end
        rst_tab[4].exp = ALL1;

        reg_tab[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0, "wr_rise"};
        reg_tab[1]  = '{1'b0, 3'd1, 32'h0, ALL1,          "rise_en_upper_ignored"};
        reg_tab[2]  = '{1'b1, 3'd2, 32'h0001_2345, 32'h0, "wr_mask"};
        reg_tab[3]  = '{1'b0, 3'd2, 32'h0, 32'h0001_2345, "irq_mask_rw"};
        reg_tab[4]  = '{1'b1, 3'd4, 32'h0000_ABCD, 32'h0, "wr_fall"};
        reg_tab[5]  = '{1'b0, 3'd4, 32'h0, 32'h0000_ABCD, "fall_en_rw"};
        reg_tab[6]  = '{1'b1, 3'd5, 32'h0000_FFFF, 32'h0, "wr_addr5"};
        reg_tab[7]  = '{1'b0, 3'd5, 32'h0, 32'h0,         "addr5_reads_zero"};
        reg_tab[8]  = '{1'b1, 3'd0, 32'h0000_0001, 32'h0, "wr_data"};
        reg_tab[9]  = '{1'b0, 3'd0, 32'h0, 32'h0,         "data_read_only"};
        reg_tab[10] = '{1'b1, 3'd1, 32'h0, 32'h0,         "wr_rise0"};
        reg_tab[11] = '{1'b1, 3'd4, ALL1, 32'h0,          "wr_fall1"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("irq_after_reset", {31'h0, irq}, 32'h0);
        foreach (rst_tab[i]) run_table(rst_tab[i]);
        foreach (reg_tab[i]) run_table(reg_tab[i]);
        do_write(3'd2, 32'h0);

        // All inputs high: rising edges only, RISE_EN is 0 so nothing captured.
        in_port = ALL1[WIDTH-1:0];
        wait_cycles(12);
        rd_check(3'd0, ALL1, "data_all_high");
        rd_check(3'd3, 32'h0, "no_capture_on_rise");

        // Bit5 falls and is held.
        do_write(3'd2, 32'h20);
        in_port[5] = 1'b0;
        wait_cycles(10);
        rd_check(3'd3, 32'h20, "cap_bit5_fall");
        check("irq_bit5", {31'h0, irq}, 32'h1);
        rd_check(3'd0, 32'h3_FFDF, "data_bit5_low");
        do_write(3'd3, 32'h20);
        rd_check(3'd3, 32'h0, "cap_cleared");
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Bits 0 and 5 fall together; clear only bit0.
        in_port[5] = 1'b1;
        wait_cycles(12);
        in_port[0] = 1'b0; in_port[5] = 1'b0;
        wait_cycles(12);
        rd_check(3'd3, 32'h21, "cap_0x21");
        do_write(3'd3, 32'h01);
        rd_check(3'd3, 32'h20, "cap_partial_clear");
        check("irq_stays", {31'h0, irq}, 32'h1);

        // Clear and new event on the same edge: set wins.
        in_port = ALL1[WIDTH-1:0];
        wait_cycles(12);
        do_write(3'd3, ALL1);
        rd_check(3'd3, 32'h0, "cap_clear_all");
        in_port[5] = 1'b0;
        repeat (EVT_PRE) @(posedge clk);
        @(negedge clk);
        do_write(3'd3, 32'h20);
        rd_check(3'd3, 32'h20, "set_beats_clear");
        in_port[5] = 1'b1;
        wait_cycles(12);
        do_write(3'd3, ALL1);
        do_write(3'd2, 32'h0);

        // Three-cycle low glitch on bit0.
        in_port[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_port[0] = 1'b1;
        wait_cycles(12);
        rd_check(3'd0, ALL1, "data_after_glitch");
        rd_check(3'd3, DEB_ON ? 32'h0 : 32'h1, "cap_after_3cyc_glitch");
        do_write(3'd3, ALL1);

        // One-cycle pulse: captured only without debounce.
        in_port[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_port[0] = 1'b1;
        wait_cycles(12);
        rd_check(3'd3, DEB_ON ? 32'h0 : 32'h1, "cap_after_1cyc_pulse");
        do_write(3'd3, ALL1);

        // Four-cycle low pulse qualifies.
        in_port[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        in_port[0] = 1'b1;
        wait_cycles(12);
        rd_check(3'd3, 32'h1, "cap_after_4cyc_pulse");
        do_write(3'd3, ALL1);

        // Long low: DATA follows.
        in_port[0] = 1'b0;
        wait_cycles(12);
        rd_check(3'd0, 32'h3_FFFE, "data_bit0_low");
        rd_check(3'd3, 32'h1, "cap_bit0_long_low");
        do_write(3'd3, ALL1);

        // Rise-only capture.
        do_write(3'd1, 32'h1);
        do_write(3'd4, 32'h0);
        in_port[0] = 1'b1;
        wait_cycles(12);
        rd_check(3'd3, 32'h1, "cap_rise_only");
        do_write(3'd3, ALL1);
        in_port[0] = 1'b0;
        wait_cycles(12);
        rd_check(3'd3, 32'h0, "no_cap_on_fall");
        do_write(3'd4, ALL1);
        wait_cycles(3);
        rd_check(3'd3, 32'h0, "no_retro_capture");

        // Reset while a capture is pending and irq is high.
        do_write(3'd2, 32'h1);
        in_port[0] = 1'b1;
        wait_cycles(12);
        check("irq_before_reset", {31'h0, irq}, 32'h1);
        in_port[0] = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("irq_cycle_after_reset", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        in_port = '0;
        foreach (rst_tab[i]) run_table(rst_tab[i]);
        wait_cycles(12);
        rd_check(3'd3, 32'h0, "no_event_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded 200000, expected completion");
        $fatal(1, "timeout");
    end

endmodule
